// File: rtl/blocking_writer_mc_pkg.sv
// Shared types for the multi-channel blocking writer: section encoding and
// channel-index sizing.
package blocking_writer_mc_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    WRITE = 1'b1
  } section_e;

  // Index width for n channels, never narrower than one bit
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = ch_idx_w(DEF_NUM_CH);

  typedef logic [DEF_CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/blocking_writer_mc_if.sv
// Blocking output bundle: per-channel data, writer notify and consumer sync.
interface blocking_writer_mc_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);

  logic [NUM_CH*WIDTH-1:0] b_out;
  logic [NUM_CH-1:0]       b_out_sync;
  logic [NUM_CH-1:0]       b_out_notify;

  modport master (
    output b_out,
    output b_out_notify,
    input  b_out_sync
  );

  modport slave (
    input  b_out,
    input  b_out_notify,
    output b_out_sync
  );

endinterface

// File: rtl/blocking_writer_mc_rr_pick.sv
// bw_rr_pick: combinational round-robin picker, searching from i_cur+1 and
// wrapping so that i_cur itself is the last candidate.
module bw_rr_pick
  import blocking_writer_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [CH_W-1:0]   i_cur,
  input  logic [NUM_CH-1:0] i_en,
  output logic [CH_W-1:0]   o_next,
  output logic              o_valid
);

  logic [CH_W-1:0] w_idx;

  // Walk candidates farthest-first so the nearest enabled one wins last
  always_comb begin
    o_next  = i_cur;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = CH_W'((int'(i_cur) + k) % NUM_CH);
      if (i_en[w_idx]) begin
        o_next  = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blocking_writer_mc.sv
// Multi-channel blocking writer: streams a stepping value register round-robin
// over enabled channels. Macro BLOCKING_WRITER_MC_NB_WRITE_EN adds non-blocking writes.
module blocking_writer_mc
  import blocking_writer_mc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int INIT_VAL = 4,
  parameter int STEP     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NUM_CH-1:0]    ch_en,
  blocking_writer_mc_if.master bus,
  output logic [WIDTH-1:0]     var_value,
  output logic [CNT_W-1:0]     write_count
`ifdef BLOCKING_WRITER_MC_NB_WRITE_EN
  ,
  input  logic                 nb_mode,
  output logic                 nb_result
`endif
);

  localparam int              CH_W   = ch_idx_w(NUM_CH);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  section_e          r_state;
  logic [CH_W-1:0]   r_cur;
  logic [NUM_CH-1:0] r_notify;
  logic [WIDTH-1:0]  r_value;
  logic [CNT_W-1:0]  r_count;
  logic              r_nb;

  logic [CH_W-1:0]   w_next;
  logic              w_valid;
  logic              w_start;
  logic              w_sync;
  logic              w_nb_sel;

  bw_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .i_cur   (r_cur),
    .i_en    (ch_en),
    .o_next  (w_next),
    .o_valid (w_valid)
  );

  assign w_start = (r_state == RUN) && !hold && w_valid;
  assign w_sync  = bus.b_out_sync[r_cur];

`ifdef BLOCKING_WRITER_MC_NB_WRITE_EN
  logic r_nb_result;
  assign w_nb_sel  = nb_mode;
  assign nb_result = r_nb_result;
`else
  assign w_nb_sel  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= WRITE;
      r_cur    <= '0;
      r_notify <= NUM_CH'(1);
      r_value  <= INIT_W;
      r_count  <= '0;
      r_nb     <= 1'b0;
`ifdef BLOCKING_WRITER_MC_NB_WRITE_EN
      r_nb_result <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (w_start) begin
            r_cur    <= w_next;
            r_notify <= NUM_CH'(1) << w_next;
            r_nb     <= w_nb_sel;
            r_state  <= WRITE;
          end else begin
            r_notify <= '0;
          end
        end
        WRITE: begin
          // A non-blocking write gets exactly one cycle; a blocking one waits for sync
          if (w_sync || r_nb) begin
            r_notify <= '0;
            r_state  <= RUN;
            if (w_sync) begin
              r_value <= r_value + STEP_W;
              r_count <= r_count + CNT_W'(1);
            end
`ifdef BLOCKING_WRITER_MC_NB_WRITE_EN
            if (r_nb) r_nb_result <= w_sync;
`endif
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Each channel's field is loaded only when that channel is picked
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] r_field;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_field <= (gi == 0) ? INIT_W : '0;
      end else if (w_start && (w_next == CH_W'(gi))) begin
        r_field <= r_value;
      end
    end
    assign bus.b_out[gi*WIDTH +: WIDTH] = r_field;
  end

  assign bus.b_out_notify = r_notify;
  assign var_value        = r_value;
  assign write_count      = r_count;

endmodule

// File: doc/blocking_writer_mc.md
# blocking_writer_mc

Parametrised multi-channel blocking writer. It drives an internal value register out over `NUM_CH` blocking output ports using the codebase's sync/notify handshake, serving enabled channels round-robin. It is a generalisation of the single-port writer skeleton, with configurable width, channel count and start value, per-channel enables, flow hold, and an optional non-blocking write mode. It sits between a generated control section and downstream blocking consumers.

## Interface
- `NUM_CH`, 4: number of output channels, ≥1
- `WIDTH`, 32: data width of the value register and of each channel
- `INIT_VAL`, 4: reset value of the value register
- `STEP`, 1: increment applied after each completed write, modulo 2^WIDTH
- `CNT_W`, 16: width of the completed-write counter
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `hold`  in  1  when high, no new write is started from RUN
- `ch_en`  in  NUM_CH  per-channel enable for round-robin selection
- `b_out`  out  NUM_CH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- `b_out_sync`  in  NUM_CH  consumer ready, one bit per channel
- `b_out_notify`  out  NUM_CH  writer valid, one bit per channel, at most one bit high
- `var_value`  out  WIDTH  current value register
- `write_count`  out  CNT_W  number of completed writes; wraps
- `nb_mode`  in  1  non-blocking mode select; present only with macro
- `nb_result`  out  1  outcome of the last non-blocking write; present only with macro

## Operation
- Sections (state machine): RUN, WRITE.
- Reset values:
  - section = WRITE; current channel = 0
  - `b_out_notify` = 1 on channel 0, 0 on all others
  - channel 0 of `b_out` = INIT_VAL; other channels = 0
  - `var_value` = INIT_VAL; `write_count` = 0; `nb_result` = 0
  - The reset write always targets channel 0, regardless of `ch_en`.
- RUN:
  - If `hold`=0 and any `ch_en` bit is set, pick the next enabled channel, searching from current+1 and wrapping modulo NUM_CH.
  - The picked channel's `b_out` field loads `var_value`, its notify goes high, and the section moves to WRITE.
  - If `hold`=1 or no channel is enabled, stay in RUN with all notify bits low.
- WRITE, blocking:
  - Notify and data on the selected channel are held until a cycle in which that channel's `b_out_sync`=1. That cycle is the transfer.
  - On the next edge: notify drops, `var_value` += STEP (wraps), `write_count` += 1 (wraps), section moves to RUN.
- Sync bits on unselected channels are ignored.
- Changes to `ch_en` or `hold` during WRITE never abort the write in progress.
- Each `b_out` field keeps its last written value while its channel is idle.
- Reset asserted mid-write: all state returns to reset values immediately. The in-flight transfer is lost and is not counted.

## Timing
- Reset release: the channel 0 transfer can complete in the first cycle if sync is high.
- RUN→WRITE takes 1 cycle. The minimum period per write is therefore 2 cycles (notify high, then one RUN cycle).
- Notify is registered. Data is stable for the whole time notify is high.
- `var_value` and `write_count` update on the edge after the transfer cycle.

## Configuration
- Macro: `BLOCKING_WRITER_MC_NB_WRITE_EN`.
- Defined: `nb_mode` and `nb_result` exist. `nb_mode` is sampled on RUN→WRITE.
  - If `nb_mode` was 1, notify is high for exactly one cycle.
  - If sync is high in that cycle: `nb_result`=1, `var_value` and `write_count` advance as for a blocking write.
  - If sync is low: `nb_result`=0, `var_value` and `write_count` are unchanged, and the data is dropped.
  - Either way the section returns to RUN.
  - `nb_result` holds until the next non-blocking write.
- Undefined: both ports are absent and all writes are blocking.

## Structure
- Package `blocking_writer_mc_pkg`:
  - sections enum (RUN, WRITE)
  - channel index type sized $clog2(NUM_CH) with a minimum of 1 bit
- Sub-module `bw_rr_pick`: combinational round-robin picker.
  - Inputs: current index, `ch_en`.
  - Outputs: next index, valid.

## Test plan
- Reset, `b_out_sync[0]` high → channel 0 transfers 4 in cycle 0; next edge `var_value`=5, `write_count`=1.
- `ch_en`=4'b1010, sync always high → channel order 0 (reset), 1, 3, 1, 3 with values 4, 5, 6, 7, 8.
- Selected channel's sync held low for 7 cycles, then high → notify high for 8 cycles, data stable, exactly one count increment.
- `hold`=1 after the first write → no notify and RUN held; release `hold` → next enabled channel written one cycle later.
- Reset pulsed low during a stalled WRITE on channel 2 → notify moves to channel 0, `var_value`=4, `write_count`=0.
- With macro: `nb_mode`=1, sync low → one-cycle notify, `nb_result`=0, `var_value` unchanged; repeat with sync high → `nb_result`=1, value advances.
